// File: rtl/halfstrip_hit_checker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// halfstrip_hit_checker
//
// Pulse-synchronous hit checker placed after the triad decoders. Each accepted
// arm strobe (the injector fire strobe) starts one trial: wait `latency`
// cycles, OR the masked half-strip hits over a capture window of
// max(window,1) cycles, then compare the result against the masked expected
// pattern. Trial results and saturating trial/error counters are held for the
// serial register interface.
//
// Ports:
//   clk                 40 MHz comparator clock
//   reset               synchronous active-high reset
//   arm                 one-cycle trial start strobe (ignored unless idle)
//   latency             cycles from arm to window open, sampled at arm
//   window              capture length in cycles (0 treated as 1), sampled at arm
//   halfstrips          decoded half-strip hits
//   halfstrips_expect   expected hit pattern, sampled at arm
//   active_strip_mask   1 = strip participates, sampled at arm
//   errcnt_rst          level; clears errcnt and trials (wins over an update)
//   busy                high from the cycle after arm through the done cycle
//   done                one-cycle strobe, trial results valid
//   mismatch            result of the last completed trial
//   halfstrips_last     masked OR of hits captured in the last trial
//   errcnt              mismatching trials, saturating
//   trials              completed trials, saturating
// -----------------------------------------------------------------------------
module halfstrip_hit_checker #(
    parameter int NSTRIPS = 32,
    parameter int LAT_W   = 6,
    parameter int WIN_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arm,
    input  logic [LAT_W-1:0]   latency,
    input  logic [WIN_W-1:0]   window,
    input  logic [NSTRIPS-1:0] halfstrips,
    input  logic [NSTRIPS-1:0] halfstrips_expect,
    input  logic [NSTRIPS-1:0] active_strip_mask,
    input  logic               errcnt_rst,
    output logic               busy,
    output logic               done,
    output logic               mismatch,
    output logic [NSTRIPS-1:0] halfstrips_last,
    output logic [31:0]        errcnt,
    output logic [31:0]        trials
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    state_t             state_r,    state_nxt_s;
    logic [LAT_W-1:0]   lat_cnt_r,  lat_cnt_nxt_s;
    logic [WIN_W-1:0]   win_cnt_r,  win_cnt_nxt_s;
    logic [NSTRIPS-1:0] expect_l_r, expect_l_nxt_s;
    logic [NSTRIPS-1:0] mask_l_r,   mask_l_nxt_s;
    logic [NSTRIPS-1:0] accum_r,    accum_nxt_s;
    logic [NSTRIPS-1:0] last_r,     last_nxt_s;
    logic               mismatch_r, mismatch_nxt_s;
    logic [31:0]        errcnt_r,   errcnt_nxt_s;
    logic [31:0]        trials_r,   trials_nxt_s;
    logic               busy_r;
    logic               done_r;

    logic [NSTRIPS-1:0] accum_capture_s;
    logic               trial_end_s;
    logic               trial_bad_s;

    assign accum_capture_s = accum_r | (halfstrips & mask_l_r);

    // Next-state and trial datapath: config latch, latency countdown, capture window.
    always_comb begin
        state_nxt_s    = state_r;
        lat_cnt_nxt_s  = lat_cnt_r;
        win_cnt_nxt_s  = win_cnt_r;
        expect_l_nxt_s = expect_l_r;
        mask_l_nxt_s   = mask_l_r;
        accum_nxt_s    = accum_r;
        last_nxt_s     = last_r;
        mismatch_nxt_s = mismatch_r;
        trial_end_s    = 1'b0;
        trial_bad_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arm) begin
                    lat_cnt_nxt_s  = latency;
                    win_cnt_nxt_s  = (window == {WIN_W{1'b0}}) ? WIN_W'(1) : window;
                    expect_l_nxt_s = halfstrips_expect;
                    mask_l_nxt_s   = active_strip_mask;
                    accum_nxt_s    = {NSTRIPS{1'b0}};
                    state_nxt_s    = (latency != {LAT_W{1'b0}}) ? ST_WAIT : ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Leaving at count 1 puts the first capture at cycle latency+1.
                if (lat_cnt_r <= LAT_W'(1)) begin
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    lat_cnt_nxt_s = lat_cnt_r - LAT_W'(1);
                end
            end
            ST_CAPTURE: begin
                accum_nxt_s = accum_capture_s;
                if (win_cnt_r <= WIN_W'(1)) begin
                    // Final capture edge: publish results from the updated accumulator.
                    state_nxt_s    = ST_DONE;
                    last_nxt_s     = accum_capture_s;
                    mismatch_nxt_s = (accum_capture_s != (expect_l_r & mask_l_r));
                    trial_end_s    = 1'b1;
                    trial_bad_s    = (accum_capture_s != (expect_l_r & mask_l_r));
                end else begin
                    win_cnt_nxt_s = win_cnt_r - WIN_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Saturating counters; errcnt_rst overrides a same-cycle update.
    always_comb begin
        errcnt_nxt_s = errcnt_r;
        trials_nxt_s = trials_r;
        if (errcnt_rst) begin
            errcnt_nxt_s = 32'd0;
            trials_nxt_s = 32'd0;
        end else if (trial_end_s) begin
            trials_nxt_s = (trials_r == CNT_MAX) ? trials_r : trials_r + 32'd1;
            if (trial_bad_s) begin
                errcnt_nxt_s = (errcnt_r == CNT_MAX) ? errcnt_r : errcnt_r + 32'd1;
            end else begin
                errcnt_nxt_s = errcnt_r;
            end
        end else begin
            errcnt_nxt_s = errcnt_r;
            trials_nxt_s = trials_r;
        end
    end

    // State and datapath registers; busy/done derived from next state so they stay registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            lat_cnt_r  <= {LAT_W{1'b0}};
            win_cnt_r  <= {WIN_W{1'b0}};
            expect_l_r <= {NSTRIPS{1'b0}};
            mask_l_r   <= {NSTRIPS{1'b0}};
            accum_r    <= {NSTRIPS{1'b0}};
            last_r     <= {NSTRIPS{1'b0}};
            mismatch_r <= 1'b0;
            errcnt_r   <= 32'd0;
            trials_r   <= 32'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            lat_cnt_r  <= lat_cnt_nxt_s;
            win_cnt_r  <= win_cnt_nxt_s;
            expect_l_r <= expect_l_nxt_s;
            mask_l_r   <= mask_l_nxt_s;
            accum_r    <= accum_nxt_s;
            last_r     <= last_nxt_s;
            mismatch_r <= mismatch_nxt_s;
            errcnt_r   <= errcnt_nxt_s;
            trials_r   <= trials_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            done_r     <= (state_nxt_s == ST_DONE);
        end
    end

    assign busy            = busy_r;
    assign done            = done_r;
    assign mismatch        = mismatch_r;
    assign halfstrips_last = last_r;
    assign errcnt          = errcnt_r;
    assign trials          = trials_r;

endmodule

// File: doc/halfstrip_hit_checker.md
# halfstrip_hit_checker

Pulse-synchronous checker that sits directly downstream of the eight triad decoders. After each injected pulse it opens a programmable capture window on the 32-bit decoded half-strip bus, ORs in the hits, and compares the masked result against the expected pattern. It returns the captured pattern, a per-trial mismatch flag, a saturating error counter and a trial counter to the serial register interface. It runs on the 40 MHz comparator clock alongside the injector, and its `arm` input is driven by the injector's fire strobe.

## Interface

Parameters:
- `NSTRIPS`, 32, width of the half-strip bus.
- `LAT_W`, 6, width of the latency field.
- `WIN_W`, 4, width of the window field.

Ports:
- `clk`  in  1  40 MHz comparator clock; the single clock for the block.
- `reset`  in  1  synchronous, active-high reset.
- `arm`  in  1  single-cycle start strobe, issued when the pulse is fired.
- `latency`  in  LAT_W  cycles from `arm` to window open; sampled at `arm`.
- `window`  in  WIN_W  capture window length in cycles; sampled at `arm`; 0 is treated as 1.
- `halfstrips`  in  NSTRIPS  decoded half-strip hits from the triad decoders.
- `halfstrips_expect`  in  NSTRIPS  expected hit pattern; sampled at `arm`.
- `active_strip_mask`  in  NSTRIPS  1 = strip participates; sampled at `arm`.
- `errcnt_rst`  in  1  level; clears `errcnt` and `trials`.
- `busy`  out  1  high from the cycle after `arm` until `done` inclusive.
- `done`  out  1  one-cycle strobe marking the trial result as valid.
- `mismatch`  out  1  result of the last completed trial.
- `halfstrips_last`  out  NSTRIPS  masked OR of hits captured in the last trial.
- `errcnt`  out  32  number of mismatching trials, saturating.
- `trials`  out  32  number of completed trials, saturating.

## Operation

States: IDLE, WAIT, CAPTURE, DONE.

**IDLE**
- On `arm`, latch `latency`, `window`, `halfstrips_expect` and `active_strip_mask`, and clear the accumulator.
- Next state is WAIT if `latency` > 0, otherwise CAPTURE.

**WAIT**
- Down-count the latched latency.
- Go to CAPTURE when the count reaches 1.

**CAPTURE**
- Each cycle: `accum <= accum | (halfstrips & mask_l)`.
- Stays for `max(window,1)` cycles.
- On the final capture edge, register the results:
  - `halfstrips_last <= final accum`.
  - `mismatch <= (final accum != (expect_l & mask_l))`.
  - `trials` increments.
  - `errcnt` increments if mismatch.
- Then go to DONE.

**DONE**
- `done` is high for this one cycle.
- Return to IDLE.

**Arithmetic**
- Both counters saturate at 0xFFFFFFFF; they never wrap.

**Boundary rules**
- `arm` while not in IDLE (WAIT/CAPTURE/DONE) is ignored: no restart and no queuing.
- Input changes to `latency`, `window`, `expect` and `mask` during a trial do not affect that trial.
- `errcnt_rst` in the same cycle as a counter update: reset wins, and both counters read 0 afterwards.
- `errcnt_rst` does not abort a trial and does not clear `mismatch` or `halfstrips_last`.
- Masked-off strips never set `halfstrips_last` bits and never cause a mismatch.
- An all-zero mask always gives `mismatch` = 0.
- `reset` mid-trial: return to IDLE next cycle, with no `done` and no counter update.

## Timing

Timing is given relative to `arm` sampled high at cycle 0.

- **Capture cycles:** `halfstrips` is sampled in cycles `latency+1` through `latency+W`, where W = max(`window`,1).
- **Done:** `done` is high in cycle `latency+W+1`.
- **Result outputs:** `halfstrips_last`, `mismatch`, `errcnt` and `trials` hold their new values from cycle `latency+W+1` onward and stay stable until the next trial completes.
- **Busy:** high from cycle 1 through cycle `latency+W+1`.
- **Re-arm:** earliest accepted re-arm is cycle `latency+W+2`.
- **Reset values:**
  - State IDLE.
  - `busy`, `done` and `mismatch` at 0.
  - `halfstrips_last`, `errcnt`, `trials` and the accumulator at 0.
  - Latched configuration at 0.
- **Pipelining:** all outputs are registered, with no combinational path from inputs to outputs.

## Test plan

- Reset, then `arm` with latency=3, window=2, mask=0xFFFFFFFF, expect=0x00000010; drive `halfstrips`=0x10 in cycle 4 only. Required: capture in cycles 4–5, `done` in cycle 6, `halfstrips_last`=0x10, `mismatch`=0, `trials`=1, `errcnt`=0.
- Same setup, but drive 0x30 in cycle 5. Required: `halfstrips_last`=0x30, `mismatch`=1, `errcnt`=1.
- Mask=0x0000FFFF, expect=0x1, hits=0x00010001; latency=0, window=0. Required: capture in cycle 1 only, `done` in cycle 2, `halfstrips_last`=0x1, `mismatch`=0.
- `arm` again in cycle 2 of a trial with latency=5, window=4. Required: ignored; exactly one `done` at cycle 10 and `trials` increments by 1 only.
- Preload `errcnt`=0xFFFFFFFF, then run a mismatching trial. Required: `errcnt` stays 0xFFFFFFFF. Separately, assert `errcnt_rst` in the `done`-update cycle. Required: `errcnt`=0 and `trials`=0 afterwards.
- Assert `reset` in cycle 2 of a trial with latency=4. Required: no `done`, `busy`=0 from cycle 3, counters unchanged at 0, and the next `arm` runs normally.
